// File: rtl/jk_bank_driver_if.sv
// Bus between the JK bank write controller, its requester and the JK bank.
// The slave modport is the controller's view; the master modport is the
// requester/bank side that offers targets and returns the bank's Q.
interface jk_bank_driver_if #(
    parameter int WIDTH = 4
) ();

    // Target word handshake.
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_valid;
    logic             tgt_ready;

    // Excitation to the bank and its readback.
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q_fb;

    // Status.
    logic             busy;
    logic             done;
    logic             err;
    logic [7:0]       err_count;

    modport master (
        output tgt_data,
        output tgt_valid,
        output q_fb,
        input  tgt_ready,
        input  j,
        input  k,
        input  busy,
        input  done,
        input  err,
        input  err_count
    );

    modport slave (
        input  tgt_data,
        input  tgt_valid,
        input  q_fb,
        output tgt_ready,
        output j,
        output k,
        output busy,
        output done,
        output err,
        output err_count
    );

endinterface

// File: rtl/jk_bank_driver.sv
// Write-side controller for a bank of JK flip-flops.
// A target word is accepted in IDLE, per-bit J/K excitation is derived from the
// bank's present Q and driven for exactly one clock, then Q is read back and
// compared. A mismatch re-drives from the new Q up to MAX_RETRY times before
// reporting err. All outputs come straight from registers.
module jk_bank_driver #(
    parameter int WIDTH       = 4,
    parameter bit TOGGLE_PREF = 1'b0,
    parameter int MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    jk_bank_driver_if.slave   bus
);

    // FSM encoding kept as plain constants for compatibility with older tools.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    // Retry counter must hold 0..MAX_RETRY; keep at least one bit so that
    // MAX_RETRY = 0 still elaborates.
    localparam int              RETRY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
    localparam logic [7:0]      ERR_CNT_MAX = 8'hFF;

    // J excitation: only bits that differ from the target are driven, so a
    // bit that is already correct is never toggled.
    function automatic logic [WIDTH-1:0] excite_j(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] t
    );
        logic [WIDTH-1:0] diff;
        diff = q ^ t;
        if (TOGGLE_PREF) begin
            return diff;
        end else begin
            return diff & t;
        end
    endfunction

    // K excitation: toggle mode uses J=K=1 on changing bits, otherwise K
    // clears the bits that must go from 1 to 0.
    function automatic logic [WIDTH-1:0] excite_k(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] t
    );
        logic [WIDTH-1:0] diff;
        diff = q ^ t;
        if (TOGGLE_PREF) begin
            return diff;
        end else begin
            return diff & ~t;
        end
    endfunction

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == ERR_CNT_MAX) begin
            return ERR_CNT_MAX;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // Registered state and outputs.
    logic [1:0]         state_r;
    logic [WIDTH-1:0]   tgt_r;
    logic [RETRY_W-1:0] retry_cnt_r;
    logic [WIDTH-1:0]   j_r;
    logic [WIDTH-1:0]   k_r;
    logic               tgt_ready_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic [7:0]         err_count_r;

    // Next-state values.
    logic [1:0]         state_s;
    logic [WIDTH-1:0]   tgt_s;
    logic [RETRY_W-1:0] retry_cnt_s;
    logic [WIDTH-1:0]   j_s;
    logic [WIDTH-1:0]   k_s;
    logic               tgt_ready_s;
    logic               busy_s;
    logic               done_s;
    logic               err_s;
    logic [7:0]         err_count_s;

    // Decoded conditions.
    logic               accept_s;
    logic               match_s;
    logic               retry_left_s;

    // Handshake and readback decode; accept can only happen while ready is high,
    // which is only ever true in IDLE.
    always_comb begin
        accept_s     = bus.tgt_valid & tgt_ready_r;
        match_s      = (bus.q_fb == tgt_r);
        retry_left_s = (retry_cnt_r < RETRY_LIMIT);
    end

    // Sequencing: IDLE -> DRIVE (one cycle) -> CHECK -> IDLE or back to DRIVE.
    // j/k are zero unless the next cycle is a DRIVE cycle.
    always_comb begin
        state_s     = state_r;
        tgt_s       = tgt_r;
        retry_cnt_s = retry_cnt_r;
        j_s         = '0;
        k_s         = '0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        err_count_s = err_count_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    tgt_s       = bus.tgt_data;
                    retry_cnt_s = '0;
                    j_s         = excite_j(bus.q_fb, bus.tgt_data);
                    k_s         = excite_k(bus.q_fb, bus.tgt_data);
                    state_s     = ST_DRIVE;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                // The bank samples j/k at the end of this cycle.
                state_s = ST_CHECK;
            end
            ST_CHECK: begin
                if (match_s) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else if (retry_left_s) begin
                    // Re-derive from the bank's current Q; it may have been
                    // disturbed externally since the previous attempt.
                    retry_cnt_s = retry_cnt_r + RETRY_ONE;
                    j_s         = excite_j(bus.q_fb, tgt_r);
                    k_s         = excite_k(bus.q_fb, tgt_r);
                    state_s     = ST_DRIVE;
                end else begin
                    err_s       = 1'b1;
                    err_count_s = sat_inc8(err_count_r);
                    state_s     = ST_IDLE;
                end
            end
            default: begin
                // Unreachable encoding: recover to a quiet IDLE.
                retry_cnt_s = '0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // Status flags follow the state being entered so they can be registered.
    always_comb begin
        if (state_s == ST_IDLE) begin
            tgt_ready_s = 1'b1;
            busy_s      = 1'b0;
        end else begin
            tgt_ready_s = 1'b0;
            busy_s      = 1'b1;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            tgt_r       <= '0;
            retry_cnt_r <= '0;
            j_r         <= '0;
            k_r         <= '0;
            tgt_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            err_count_r <= 8'h00;
        end else begin
            state_r     <= state_s;
            tgt_r       <= tgt_s;
            retry_cnt_r <= retry_cnt_s;
            j_r         <= j_s;
            k_r         <= k_s;
            tgt_ready_r <= tgt_ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            err_count_r <= err_count_s;
        end
    end

    // Drive the bus from the output registers.
    assign bus.tgt_ready = tgt_ready_r;
    assign bus.j         = j_r;
    assign bus.k         = k_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two controllers (set/reset and toggle excitation)
// share the same target stream, each writing its own 4-bit JK bank model.
// A transaction-level predictor lays out the expected per-cycle outputs at
// every accept; directed steps pin concrete values.
module tb_jk_bank_driver;

    localparam int MAXR = 2;

    typedef struct packed {
        logic       busy;
        logic       ready;
        logic       done;
        logic       err;
        logic       chk_q;
        logic [3:0] qexp;
        logic [3:0] j0;
        logic [3:0] k0;
        logic [3:0] j1;
        logic [3:0] k1;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       bank_rst;
    logic       stuck;
    logic       tgt_valid;
    logic [3:0] tgt_data;
    logic [3:0] bq0;
    logic [3:0] bq1;

    int n_chk  = 0;
    int n_fail = 0;
    int m_errcnt = 0;
    exp_t cur;
    exp_t exp_q[$];

    jk_bank_driver_if #(.WIDTH(4)) bus0 ();
    jk_bank_driver_if #(.WIDTH(4)) bus1 ();

    jk_bank_driver #(.WIDTH(4), .TOGGLE_PREF(1'b0), .MAX_RETRY(MAXR)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    jk_bank_driver #(.WIDTH(4), .TOGGLE_PREF(1'b1), .MAX_RETRY(MAXR)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus0.tgt_valid = tgt_valid;
    assign bus0.tgt_data  = tgt_data;
    assign bus1.tgt_valid = tgt_valid;
    assign bus1.tgt_data  = tgt_data;
    assign bus0.q_fb      = stuck ? 4'b0000 : bq0;
    assign bus1.q_fb      = stuck ? 4'b0000 : bq1;

    // JK flip-flop banks: Q+ = J&~Q | ~K&Q.
    always @(posedge clk) begin
        if (bank_rst) begin
            bq0 <= 4'b0000;
            bq1 <= 4'b0000;
        end else begin
            bq0 <= (bus0.j & ~bq0) | (~bus0.k & bq0);
            bq1 <= (bus1.j & ~bq1) | (~bus1.k & bq1);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
        end
    endtask

    // Excitation rule for one word: unchanged bits get J=K=0.
    function automatic logic [3:0] exc_j(input logic [3:0] q, input logic [3:0] t, input bit tog);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            if (q[i] == t[i]) r[i] = 1'b0;
            else if (tog)     r[i] = 1'b1;
            else              r[i] = t[i];
        end
        return r;
    endfunction

    function automatic logic [3:0] exc_k(input logic [3:0] q, input logic [3:0] t, input bit tog);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            if (q[i] == t[i]) r[i] = 1'b0;
            else if (tog)     r[i] = 1'b1;
            else              r[i] = ~t[i];
        end
        return r;
    endfunction

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // Lay out the whole operation: attempts of (drive, check), then done or err.
    // A healthy bank reaches the target after one drive; a stuck readback is 0.
    task automatic build(input logic [3:0] t, input logic [3:0] qa0, input logic [3:0] qb0, input bit stk);
        logic [3:0] qa;
        logic [3:0] qb;
        exp_t e;
        qa = qa0;
        qb = qb0;
        for (int a = 0; a <= MAXR; a++) begin
            e = '0;
            e.busy = 1'b1;
            e.j0 = exc_j(qa, t, 1'b0);
            e.k0 = exc_k(qa, t, 1'b0);
            e.j1 = exc_j(qb, t, 1'b1);
            e.k1 = exc_k(qb, t, 1'b1);
            exp_q.push_back(e);
            e = '0;
            e.busy = 1'b1;
            exp_q.push_back(e);
            qa = stk ? 4'b0000 : t;
            qb = qa;
            if (qa == t) begin
                e = idle_e();
                e.done = 1'b1;
                e.chk_q = 1'b1;
                e.qexp = t;
                exp_q.push_back(e);
                break;
            end else if (a == MAXR) begin
                e = idle_e();
                e.err = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Predictor and compare process: update at posedge, check at negedge.
    initial begin
        cur = idle_e();
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.delete();
                m_errcnt = 0;
            end else if (cur.ready && tgt_valid) begin
                build(tgt_data, bus0.q_fb, bus1.q_fb, stuck);
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else                  cur = idle_e();
            if (cur.err) m_errcnt = (m_errcnt == 255) ? 255 : m_errcnt + 1;
            @(negedge clk);
            chk("m_ready0", {7'd0, bus0.tgt_ready}, {7'd0, cur.ready});
            chk("m_ready1", {7'd0, bus1.tgt_ready}, {7'd0, cur.ready});
            chk("m_busy0",  {7'd0, bus0.busy},      {7'd0, cur.busy});
            chk("m_busy1",  {7'd0, bus1.busy},      {7'd0, cur.busy});
            chk("m_done0",  {7'd0, bus0.done},      {7'd0, cur.done});
            chk("m_done1",  {7'd0, bus1.done},      {7'd0, cur.done});
            chk("m_err0",   {7'd0, bus0.err},       {7'd0, cur.err});
            chk("m_err1",   {7'd0, bus1.err},       {7'd0, cur.err});
            chk("m_j0", {4'd0, bus0.j}, {4'd0, cur.j0});
            chk("m_k0", {4'd0, bus0.k}, {4'd0, cur.k0});
            chk("m_j1", {4'd0, bus1.j}, {4'd0, cur.j1});
            chk("m_k1", {4'd0, bus1.k}, {4'd0, cur.k1});
            chk("m_errcnt0", bus0.err_count, 8'(m_errcnt));
            chk("m_errcnt1", bus1.err_count, 8'(m_errcnt));
            if (cur.chk_q) begin
                chk("m_q0", {4'd0, bus0.q_fb}, {4'd0, cur.qexp});
                chk("m_q1", {4'd0, bus1.q_fb}, {4'd0, cur.qexp});
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present a word for one cycle; returns in the DRIVE cycle.
    task automatic offer(input logic [3:0] d);
        tgt_data  = d;
        tgt_valid = 1'b1;
        step();
        tgt_valid = 1'b0;
    endtask

    int ndone;

    initial begin
        reset = 1'b1; bank_rst = 1'b1; stuck = 1'b0;
        tgt_valid = 1'b0; tgt_data = 4'b0000;
        repeat (3) step();
        reset = 1'b0; bank_rst = 1'b0;
        step();
        chk("rst_ready", {7'd0, bus0.tgt_ready}, 8'd1);
        chk("rst_busy",  {7'd0, bus0.busy},      8'd0);
        chk("rst_jk",    {bus0.j, bus0.k},       8'h00);
        chk("rst_errcnt", bus0.err_count,        8'd0);

        // Word from 0000 to 1010.
        offer(4'b1010);
        chk("s1_j0", {4'd0, bus0.j}, 8'b0000_1010);
        chk("s1_k0", {4'd0, bus0.k}, 8'b0000_0000);
        chk("s1_jk1", {bus1.j, bus1.k}, 8'b1010_1010);
        step(); step();
        chk("s1_done", {7'd0, bus0.done}, 8'd1);
        chk("s1_err",  {7'd0, bus0.err},  8'd0);
        chk("s1_q",    {bq0, bq1},        8'b1010_1010);

        // 1010 -> 0110, offered in the done cycle.
        offer(4'b0110);
        chk("s2_j0", {4'd0, bus0.j}, 8'b0000_0100);
        chk("s2_k0", {4'd0, bus0.k}, 8'b0000_1000);
        chk("s2_jk1", {bus1.j, bus1.k}, 8'b1100_1100);
        step(); step();
        chk("s2_done", {bus0.done, bus1.done}, 2'b11);
        chk("s2_q",    {bq0, bq1}, 8'b0110_0110);

        // Same word again: hold excitation, still completes.
        offer(4'b0110);
        chk("s3_jk", {bus0.j, bus0.k, bus1.j, bus1.k}, 16'h0000);
        chk("s3_busy", {7'd0, bus0.busy}, 8'd1);
        step(); step();
        chk("s3_done", {7'd0, bus0.done}, 8'd1);
        chk("s3_q",    {bq0, bq1}, 8'b0110_0110);

        // Stuck readback: three drives then err in cycle 7.
        stuck = 1'b1;
        offer(4'b1111);
        chk("s4_j0_a", {4'd0, bus0.j}, 8'b0000_1111);
        step(); step();
        chk("s4_j0_b", {4'd0, bus0.j}, 8'b0000_1111);
        chk("s4_jk1_b", {bus1.j, bus1.k}, 8'b1111_1111);
        step(); step();
        chk("s4_j0_c", {4'd0, bus0.j}, 8'b0000_1111);
        step(); step();
        chk("s4_err",  {bus0.err, bus0.done}, 2'b10);
        chk("s4_errcnt", bus0.err_count, 8'd1);
        tgt_data = 4'b1111;
        tgt_valid = 1'b1;
        repeat (7 * 262) step();
        tgt_valid = 1'b0;
        repeat (10) step();
        chk("s4_sat0", bus0.err_count, 8'd255);
        chk("s4_sat1", bus1.err_count, 8'd255);
        stuck = 1'b0;

        // Reset during DRIVE.
        offer(4'b0101);
        chk("s6_busy", {7'd0, bus0.busy}, 8'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s6_ready", {bus0.tgt_ready, bus1.tgt_ready}, 2'b11);
        chk("s6_jk", {bus0.j, bus0.k, bus1.j, bus1.k}, 16'h0000);
        chk("s6_errcnt", bus0.err_count, 8'd0);
        for (int i = 0; i < 4; i++) begin
            chk("s6_quiet", {bus0.done, bus0.err, bus1.done, bus1.err}, 4'b0000);
            step();
        end

        // Valid held with changing data: back-to-back words every 3 cycles.
        ndone = 0;
        tgt_data = 4'($urandom);
        tgt_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus0.done === 1'b1) ndone++;
            tgt_data = 4'($urandom);
        end
        tgt_valid = 1'b0;
        chk("s5_ndone", 8'(ndone), 8'd10);
        repeat (4) step();

        // Randomized traffic with occasional stuck readback and resets.
        for (int i = 0; i < 1500; i++) begin
            tgt_valid = ($urandom_range(0, 2) != 0);
            tgt_data  = 4'($urandom);
            if (exp_q.size() == 0 && $urandom_range(0, 15) == 0) stuck = ~stuck;
            reset = ($urandom_range(0, 79) == 0);
            step();
        end
        reset = 1'b0;
        tgt_valid = 1'b0;
        stuck = 1'b0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
